// File: rtl/tm_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module : tm_sched_pkg
// Brief  : Shared defaults, thread-id type and in-flight tracking entry for
//          the transaction-length update scheduler.
// Rev    : 1.0  initial release
// ============================================================================
package tm_sched_pkg;

    localparam int NUM_THREADS_DEF = 4;
    localparam int TXLEN_W_DEF     = 8;
    localparam int EXED_W_DEF      = 8;
    localparam int ALU_LAT_DEF     = 4;

    // Thread ids are carried at a fixed maximum width so one struct serves
    // any NUM_THREADS up to 256; modules zero-extend into it and slice out.
    localparam int TID_MAX_W = 8;
    typedef logic [TID_MAX_W-1:0] tid_t;

    // One stage of the in-flight tracker, moving in lockstep with the ALU.
    typedef struct packed {
        logic valid;
        tid_t tid;
        logic kill;
    } sr_entry_t;

    // Round-robin successor: the thread after idx, wrapping at n.
    function automatic int rr_next(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tm_rr_arb.sv
`default_nettype none
// ============================================================================
// Module : tm_rr_arb
// Brief  : Round-robin arbiter. Grants at most one requester per cycle; after
//          a grant to i, requester i+1 (mod N) has highest priority.
// Rev    : 1.0  initial release
// ============================================================================
module tm_rr_arb
    import tm_sched_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             gnt_any_o
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] idx;
    logic             found;

    // Scan requesters starting at the pointer; the first one found wins.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = '0;
        for (int i = 0; i < N; i++) begin
            idx = IDX_W'((int'(ptr_q) + i) % N);
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = idx;
            end
        end
    end

    assign gnt_any_o = found;

    // Move priority to the requester just after the one granted.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (found) begin
            ptr_q <= IDX_W'(rr_next(int'(gnt_idx_o), N));
        end
    end

endmodule
`default_nettype wire

// File: rtl/tm_update_sched.sv
`default_nettype none
// ============================================================================
// Module : tm_update_sched
// Brief  : Per-thread running-average table updater. Arbitrates thread
//          requests round-robin, feeds the external running-average ALU and
//          writes its results back ALU_LAT cycles later. Clears may kill
//          in-flight operations.
//          Build option TM_SCHED_SAT_EN: requests hitting a saturated
//          execution count are accepted and dropped instead of restarting
//          the entry.
// Rev    : 1.0  initial release
// ============================================================================
module tm_update_sched
    import tm_sched_pkg::*;
#(
    parameter int NUM_THREADS = NUM_THREADS_DEF,
    parameter int TXLEN_W     = TXLEN_W_DEF,
    parameter int EXED_W      = EXED_W_DEF,
    parameter int ALU_LAT     = ALU_LAT_DEF
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_THREADS-1:0]           req_valid,
    input  logic [NUM_THREADS*TXLEN_W-1:0]   req_len,
    output logic [NUM_THREADS-1:0]           req_ready,
    input  logic                             clr_valid,
    input  logic [$clog2(NUM_THREADS)-1:0]   clr_tid,
    output logic [TXLEN_W-1:0]               alu_avg_o,
    output logic [EXED_W-1:0]                alu_exed_o,
    output logic [TXLEN_W-1:0]               alu_cur_o,
    input  logic [TXLEN_W-1:0]               alu_avg_i,
    input  logic [EXED_W-1:0]                alu_exed_i,
    input  logic [$clog2(NUM_THREADS)-1:0]   rd_tid,
    output logic [TXLEN_W-1:0]               rd_avg,
    output logic [EXED_W-1:0]                rd_exed,
    output logic                             busy
);

    localparam int TID_W = $clog2(NUM_THREADS);

    logic [TXLEN_W-1:0]     avg_q   [NUM_THREADS];
    logic [EXED_W-1:0]      exed_q  [NUM_THREADS];
    logic [TXLEN_W-1:0]     len_arr [NUM_THREADS];
    logic [NUM_THREADS-1:0] pend_q, pend_d;
    sr_entry_t              sr_q [ALU_LAT];
    sr_entry_t              sr_d [ALU_LAT];

    logic [NUM_THREADS-1:0] elig;
    logic [NUM_THREADS-1:0] gnt;
    logic [TID_W-1:0]       gnt_idx;
    logic                   gnt_any;
    logic                   sat;
    logic                   issue;
    logic                   restart;
    logic                   wb_en;
    logic [TID_W-1:0]       wb_tid;
    logic                   inflight;

    // Split the packed length bus into one lane per thread.
    for (genvar g = 0; g < NUM_THREADS; g++) begin : g_len_unpack
        assign len_arr[g] = req_len[g*TXLEN_W +: TXLEN_W];
    end

    // A thread competes only when requesting, idle, and not being cleared.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            elig[i] = req_valid[i] & ~pend_q[i]
                    & ~(clr_valid && (int'(clr_tid) == i));
        end
        if (reset) begin
            elig = '0;
        end
    end

    tm_rr_arb #(
        .N     (NUM_THREADS),
        .IDX_W (TID_W)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req_i     (elig),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .gnt_any_o (gnt_any)
    );

    assign req_ready = gnt;
    assign sat       = (exed_q[gnt_idx] == '1);

    // A saturated count either drops the request or restarts the average.
`ifdef TM_SCHED_SAT_EN
    assign issue   = gnt_any & ~sat;
    assign restart = 1'b0;
`else
    assign issue   = gnt_any;
    assign restart = sat;
`endif

    // ALU operands exist only in a cycle that issues; zero otherwise.
    always_comb begin
        alu_avg_o  = '0;
        alu_exed_o = '0;
        alu_cur_o  = '0;
        if (issue) begin
            alu_cur_o = len_arr[gnt_idx];
            if (!restart) begin
                alu_avg_o  = avg_q[gnt_idx];
                alu_exed_o = exed_q[gnt_idx];
            end
        end
    end

    // The oldest tracker stage lines up with the ALU result this cycle.
    assign wb_en  = sr_q[ALU_LAT-1].valid & ~sr_q[ALU_LAT-1].kill;
    assign wb_tid = sr_q[ALU_LAT-1].tid[TID_W-1:0];

    // Advance the tracker, marking ops of a thread being cleared as killed.
    always_comb begin
        sr_d[0].valid = issue;
        sr_d[0].tid   = tid_t'(gnt_idx);
        sr_d[0].kill  = 1'b0;
        for (int k = 1; k < ALU_LAT; k++) begin
            sr_d[k] = sr_q[k-1];
            if (clr_valid && sr_q[k-1].valid
                && (sr_q[k-1].tid == tid_t'(clr_tid))) begin
                sr_d[k].kill = 1'b1;
            end
        end
    end

    // Pending bits: set on issue, released when the op leaves the tracker.
    always_comb begin
        pend_d = pend_q;
        if (sr_q[ALU_LAT-1].valid) begin
            pend_d[wb_tid] = 1'b0;
        end
        if (issue) begin
            pend_d[gnt_idx] = 1'b1;
        end
    end

    // Tracker and pending state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= '0;
            for (int k = 0; k < ALU_LAT; k++) begin
                sr_q[k] <= '0;
            end
        end else begin
            pend_q <= pend_d;
            for (int k = 0; k < ALU_LAT; k++) begin
                sr_q[k] <= sr_d[k];
            end
        end
    end

    // Table update: writeback first so a same-cycle clear overrides it.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                avg_q[i]  <= '0;
                exed_q[i] <= '0;
            end
        end else begin
            if (wb_en) begin
                avg_q[wb_tid]  <= alu_avg_i;
                exed_q[wb_tid] <= alu_exed_i;
            end
            if (clr_valid) begin
                avg_q[clr_tid]  <= '0;
                exed_q[clr_tid] <= '0;
            end
        end
    end

    // Busy whenever any tracker stage holds an op.
    always_comb begin
        inflight = 1'b0;
        for (int k = 0; k < ALU_LAT; k++) begin
            inflight = inflight | sr_q[k].valid;
        end
    end

    assign busy    = inflight & ~reset;
    assign rd_avg  = avg_q[rd_tid];
    assign rd_exed = exed_q[rd_tid];

endmodule
`default_nettype wire

// File: tb/tb_tm_update_sched.sv
`default_nettype none
// ============================================================================
// Module : tb_tm_update_sched
// Brief  : Self-checking bench for tm_update_sched with a latency-matched
//          running-average ALU model and a grant scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
module tb_tm_update_sched;

    localparam int NT  = 4;
    localparam int TW  = 8;
    localparam int EW  = 8;
    localparam int LAT = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NT-1:0]     req_valid = '0;
    logic [NT*TW-1:0]  req_len = '0;
    logic [NT-1:0]     req_ready;
    logic              clr_valid = 1'b0;
    logic [1:0]        clr_tid = '0;
    logic [TW-1:0]     alu_avg_o, alu_cur_o, alu_avg_i, rd_avg;
    logic [EW-1:0]     alu_exed_o, alu_exed_i, rd_exed;
    logic [1:0]        rd_tid = '0;
    logic              busy;
    logic              ovr = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int tid;
        int avg;
        int exed;
        int cur;
    } exp_t;
    exp_t sb[$];

    logic [TW-1:0] p_avg  [LAT];
    logic [EW-1:0] p_exed [LAT];
    logic [3:0]    exp_g  [6];

    tm_update_sched #(
        .NUM_THREADS (NT),
        .TXLEN_W     (TW),
        .EXED_W      (EW),
        .ALU_LAT     (LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_len    (req_len),
        .req_ready  (req_ready),
        .clr_valid  (clr_valid),
        .clr_tid    (clr_tid),
        .alu_avg_o  (alu_avg_o),
        .alu_exed_o (alu_exed_o),
        .alu_cur_o  (alu_cur_o),
        .alu_avg_i  (alu_avg_i),
        .alu_exed_i (alu_exed_i),
        .rd_tid     (rd_tid),
        .rd_avg     (rd_avg),
        .rd_exed    (rd_exed),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Running-average ALU: captures operands at the edge, result LAT cycles on.
    always @(posedge clk) begin
        if (ovr) begin
            p_avg[0]  <= TW'(50);
            p_exed[0] <= EW'(255);
        end else begin
            p_avg[0]  <= TW'((int'(alu_avg_o) * int'(alu_exed_o) + int'(alu_cur_o))
                             / (int'(alu_exed_o) + 1));
            p_exed[0] <= EW'(int'(alu_exed_o) + 1);
        end
        for (int k = 1; k < LAT; k++) begin
            p_avg[k]  <= p_avg[k-1];
            p_exed[k] <= p_exed[k-1];
        end
    end

    assign alu_avg_i  = p_avg[LAT-1];
    assign alu_exed_i = p_exed[LAT-1];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void push(input int tid, input int a, input int e, input int c);
        exp_t r;
        r.tid = tid; r.avg = a; r.exed = e; r.cur = c;
        sb.push_back(r);
    endfunction

    // Every grant outside reset is matched against the next expected issue.
    always @(negedge clk) begin
        if (reset === 1'b0 && req_ready !== '0) begin
            if (sb.size() == 0) begin
                check_val("unexp_gnt", 64'(req_ready), 64'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_val("gnt_onehot", 64'(req_ready), 64'(1) << e.tid);
                check_val("alu_avg",    64'(alu_avg_o),  64'(e.avg));
                check_val("alu_exed",   64'(alu_exed_o), 64'(e.exed));
                check_val("alu_cur",    64'(alu_cur_o),  64'(e.cur));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_len(input int tid, input int v);
        req_len[tid*TW +: TW] = TW'(v);
    endtask

    task automatic check_entry(input string tag, input int tid, input int a, input int e);
        rd_tid = 2'(tid);
        #1;
        check_val({tag, "_avg"},  64'(rd_avg),  64'(a));
        check_val({tag, "_exed"}, 64'(rd_exed), 64'(e));
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        req_valid = '1;
        clr_valid = 1'b0;
        req_len   = 32'h0A0B0C0D;
        step();
        step();
        mid();
        check_val("rst_ready", 64'(req_ready), 64'(0));
        check_val("rst_busy",  64'(busy), 64'(0));
        check_val("rst_alu",   64'({alu_avg_o, alu_exed_o, alu_cur_o}), 64'(0));
        step();
        req_valid = '0;
        req_len   = '0;
        reset     = 1'b0;
    endtask

    initial begin
        exp_g = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h1};

        // Single op from reset state.
        apply_reset();
        mid();
        for (int i = 0; i < NT; i++) check_entry("t1_init", i, 0, 0);
        step();
        push(0, 0, 0, 40);
        req_valid = 4'b0001; set_len(0, 40);
        mid();
        step();
        req_valid = '0;
        mid();
        check_val("t1_busy_hi", 64'(busy), 64'(1));
        repeat (4) step();
        check_val("t1_busy_lo", 64'(busy), 64'(0));
        check_entry("t1_e0", 0, 40, 1);

        // Same thread back to back: second grant waits for writeback.
        apply_reset();
        push(0, 0, 0, 40);
        push(0, 40, 1, 20);
        req_valid = 4'b0001; set_len(0, 40);
        step();
        set_len(0, 20);
        for (int k = 0; k < 4; k++) begin
            mid();
            check_val("t2_wait", 64'(req_ready), 64'(0));
            step();
        end
        mid();
        check_val("t2_regrant", 64'(req_ready), 64'(1));
        step();
        req_valid = '0;
        repeat (4) step();
        check_entry("t2_e0", 0, 30, 2);

        // All threads requesting: one issue per cycle, round robin.
        apply_reset();
        push(0, 0, 0, 10); push(1, 0, 0, 20); push(2, 0, 0, 30);
        push(3, 0, 0, 40); push(0, 10, 1, 10);
        set_len(0, 10); set_len(1, 20); set_len(2, 30); set_len(3, 40);
        req_valid = 4'hF;
        for (int k = 0; k < 6; k++) begin
            mid();
            check_val("t3_gnt", 64'(req_ready), 64'(exp_g[k]));
            step();
        end
        req_valid = '0;
        repeat (4) step();
        check_entry("t3_e0", 0, 10, 2);
        check_entry("t3_e3", 3, 40, 1);

        // Clear with an op in flight, then clear blocking a grant.
        apply_reset();
        push(2, 0, 0, 30);
        req_valid = 4'b0100; set_len(2, 30);
        step();
        req_valid = '0;
        repeat (4) step();
        check_entry("t4_pre", 2, 30, 1);
        push(2, 30, 1, 50);
        req_valid = 4'b0100; set_len(2, 50);
        mid();
        step();
        req_valid = '0;
        step();
        clr_valid = 1'b1; clr_tid = 2'd2;
        mid();
        check_val("t4_busy", 64'(busy), 64'(1));
        step();
        clr_valid = 1'b0;
        mid();
        check_entry("t4_clr", 2, 0, 0);
        step();
        step();
        check_entry("t4_kill", 2, 0, 0);
        check_val("t4_idle", 64'(busy), 64'(0));
        req_valid = 4'b0100; set_len(2, 9);
        clr_valid = 1'b1; clr_tid = 2'd2;
        mid();
        check_val("t4_blk", 64'(req_ready), 64'(0));
        step();
        clr_valid = 1'b0;
        push(2, 0, 0, 9);
        mid();
        check_val("t4_unblk", 64'(req_ready), 64'(4));
        step();
        req_valid = '0;
        repeat (4) step();
        check_entry("t4_e2", 2, 9, 1);

        // Saturated execution count.
        apply_reset();
        ovr = 1'b1;
        push(1, 0, 0, 5);
        req_valid = 4'b0010; set_len(1, 5);
        step();
        ovr = 1'b0;
        req_valid = '0;
        repeat (4) step();
        check_entry("t5_pre", 1, 50, 255);
`ifdef TM_SCHED_SAT_EN
        push(1, 0, 0, 0);
`else
        push(1, 0, 0, 7);
`endif
        req_valid = 4'b0010; set_len(1, 7);
        mid();
        check_val("t5_accept", 64'(req_ready), 64'(2));
        step();
        req_valid = '0;
        mid();
`ifdef TM_SCHED_SAT_EN
        check_val("t5_busy", 64'(busy), 64'(0));
`else
        check_val("t5_busy", 64'(busy), 64'(1));
`endif
        repeat (4) step();
`ifdef TM_SCHED_SAT_EN
        check_entry("t5_e1", 1, 50, 255);
`else
        check_entry("t5_e1", 1, 7, 1);
`endif

        // Reset mid-stream with three ops in flight.
        apply_reset();
        push(0, 0, 0, 11); push(1, 0, 0, 22); push(2, 0, 0, 33);
        set_len(0, 11); set_len(1, 22); set_len(2, 33);
        req_valid = 4'b0111;
        mid();
        step();
        mid();
        step();
        mid();
        step();
        reset = 1'b1;
        mid();
        check_val("t6_rst_ready", 64'(req_ready), 64'(0));
        check_val("t6_rst_busy",  64'(busy), 64'(0));
        check_val("t6_rst_alu",   64'(alu_cur_o), 64'(0));
        step();
        req_valid = '0;
        step();
        reset = 1'b0;
        repeat (5) step();
        mid();
        check_val("t6_busy", 64'(busy), 64'(0));
        for (int i = 0; i < NT; i++) check_entry("t6_zero", i, 0, 0);

        step();
        check_val("sb_empty", 64'(sb.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
